// File: rtl/hilo_seq_div.sv
// Iterative restoring radix-2 divider feeding the HI/LO pair: quotient to LO, remainder to HI.
// Optional macro HILO_DIV_EARLY_OUT_EN skips CALC when |divisor| > |dividend| (divisor nonzero).
module hilo_seq_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;    // partial remainder
   logic [WIDTH-1:0] qsh_q, qsh_d;    // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] dvd_mag, dsr_mag;
   logic [WIDTH:0]   acc_sh, acc_sub;
   logic             dsr_zero, early_out, accept, signed_op;

   // Divide by zero runs unsigned on the raw operands: the restoring loop then
   // naturally yields quot = all ones and rem = dividend, with unchanged latency.
   always_comb begin
      dsr_zero  = (divisor == '0);
      signed_op = is_signed && !dsr_zero;
      dvd_mag   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
      dsr_mag   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
   end

`ifdef HILO_DIV_EARLY_OUT_EN
   assign early_out = !dsr_zero && (dsr_mag > dvd_mag);
`else
   assign early_out = 1'b0;
`endif

   assign accept  = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
   assign acc_sh  = {acc_q, qsh_q[WIDTH-1]};
   assign acc_sub = acc_sh - {1'b0, dsr_q};

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      qsh_d   = qsh_q;
      dsr_d   = dsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (accept) begin
               busy_d  = 1'b1;
               cnt_d   = '0;
               dsr_d   = dsr_mag;
               neg_q_d = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_r_d = signed_op && dividend[WIDTH-1];
               if (early_out) begin
                  state_d = S_FIX;
                  acc_d   = dvd_mag;
                  qsh_d   = '0;
               end else begin
                  state_d = S_CALC;
                  acc_d   = '0;
                  qsh_d   = dvd_mag;
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               // Borrow out of the (WIDTH+1)-bit subtract means acc_sh < divisor.
               if (!acc_sub[WIDTH]) begin
                  acc_d = acc_sub[WIDTH-1:0];
                  qsh_d = {qsh_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = acc_sh[WIDTH-1:0];
                  qsh_d = {qsh_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
         end
         S_FIX: begin
            busy_d = 1'b0;
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
               quot_d  = neg_q_q ? -qsh_q : qsh_q;
               rem_d   = neg_r_q ? -acc_q : acc_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; comb logic above uses blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         qsh_q   <= '0;
         dsr_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         qsh_q   <= qsh_d;
         dsr_q   <= dsr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;
   assign rem  = rem_q;

endmodule

// File: doc/hilo_seq_div.md
# hilo_seq_div

Iterative radix-2 divider that feeds the HI/LO register pair. It computes a 32-bit quotient and remainder over a fixed multi-cycle schedule, with signed and unsigned modes. On completion it presents `{rem, quot}` with a one-cycle `done` pulse, which the pipeline uses to write HI (remainder) and LO (quotient) through the HI/LO write port. The pipeline stalls any HI/LO read while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width; the schedule runs one CALC cycle per bit.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE or DONE.
- `flush` input 1: synchronous abort of an in-flight division; dominates `start`.
- `is_signed` input 1: 1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `dividend` input WIDTH: numerator; sampled with `start`.
- `divisor` input WIDTH: denominator; sampled with `start`.
- `busy` output 1: high while a division is in progress (CALC or FIX).
- `done` output 1: one-cycle pulse when `quot` and `rem` are freshly valid.
- `quot` output WIDTH: registered quotient; holds until the next completion.
- `rem` output WIDTH: registered remainder; holds until the next completion.

## Operation
- States and transitions:
  - IDLE: on `start` -> CALC; otherwise stay.
  - CALC: -> FIX after WIDTH cycles; on `flush` -> IDLE.
  - FIX: -> DONE; on `flush` -> IDLE.
  - DONE: one cycle, then -> IDLE, or -> CALC if `start` is high in that cycle.
- Operand capture on `start`:
  - Signed mode: absolute values of `dividend` and `divisor`; record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - Unsigned mode: operands taken as-is; `neg_q` and `neg_r` cleared.
- CALC, restoring step per cycle:
  - Shift the partial remainder left by one and bring in the next dividend MSB.
  - If partial remainder ≥ divisor magnitude: subtract it and shift in a quotient bit of 1; otherwise shift in 0.
  - The step counter runs from 0 to WIDTH-1.
- FIX:
  - Negate the quotient if `neg_q`; negate the remainder if `neg_r`. Division truncates toward zero and the remainder takes the dividend's sign.
  - Load `quot` and `rem`; both update only on the FIX->DONE edge.
- Divide by zero, detected at `start`: the result is forced to `quot` = all ones, `rem` = original `dividend`. Mode is ignored and latency is unchanged.
- Overflow: 0x80000000 / 0xFFFFFFFF, signed, gives `quot` = 0x80000000 and `rem` = 0. No trap is raised.
- `start` while `busy`: ignored, not queued.
- `flush`: returns to IDLE on the next edge. `done` does not pulse and `quot`/`rem` keep their previous values.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `quot` = 0, `rem` = 0, counter = 0, internal datapath registers = 0.
- With `start` high in cycle 0:
  - CALC occupies cycles 1..WIDTH.
  - FIX occupies cycle WIDTH+1.
  - `done` is high in cycle WIDTH+2; this is cycle 34 for WIDTH = 32.
- `busy` is high in cycles 1..WIDTH+1. It is low in DONE, so a back-to-back `start` in the DONE cycle is accepted.
- `quot`/`rem` become valid in the same cycle `done` rises and remain stable until the next FIX->DONE edge.
- `rst` mid-operation: all outputs return to their reset values immediately and the operation is lost.
- `flush` and `start` in the same cycle in DONE: `flush` wins and the state goes to IDLE.

## Configuration
- `HILO_DIV_EARLY_OUT_EN`:
  - Defined: when `start` is accepted with a nonzero divisor whose magnitude exceeds the dividend magnitude, CALC is skipped. FIX runs in cycle 1 with `quot` = 0 and `rem` = original `dividend`; `done` is high in cycle 2 and `busy` is high in cycle 1 only.
  - Undefined: every division takes the full WIDTH+2 cycle latency.

## Test plan
- Unsigned 100 / 7, `start` in cycle 0 -> `quot` = 14, `rem` = 2, `done` high in cycle 34 only, `busy` high in cycles 1..33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> `quot` = 0xFFFFFFFD, `rem` = 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> `quot` = 0x80000000, `rem` = 0.
- Divide by zero, 5 / 0 in both modes -> `quot` = 0xFFFFFFFF, `rem` = 5, `done` in cycle 34.
- `start` asserted again in cycle 5 with different operands -> ignored and the first result is unaltered; a new `start` in the DONE cycle -> the next `done` is 34 cycles later.
- `flush` in cycle 10 -> `busy` low from cycle 11, no `done`, `quot`/`rem` unchanged. `rst` pulse in cycle 20 of a separate run -> all outputs 0 immediately.
- Unsigned 3 / 10 -> `quot` = 0, `rem` = 3, with `done` in cycle 2 when `HILO_DIV_EARLY_OUT_EN` is defined and cycle 34 when it is not.
